// File: rtl/pattern_capture.sv
// Change-capture FIFO: records each new value of `inputs` (optionally with a timestamp)
// into a first-word-fall-through buffer. Optional timestamping: `define PATTERN_CAPTURE_TIMESTAMP_EN.
module pattern_capture #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 16,
  parameter int TS_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cap_en,
  input  logic [WIDTH-1:0]         inputs,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [WIDTH-1:0]         rd_data,
`ifdef PATTERN_CAPTURE_TIMESTAMP_EN
  output logic [TS_W-1:0]          rd_ts,
`endif
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] last_q, last_d;
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             capture, pop, push;

  logic [WIDTH-1:0] mem_data [DEPTH];
`ifdef PATTERN_CAPTURE_TIMESTAMP_EN
  logic [TS_W-1:0]  ts_cnt_q;
  logic [TS_W-1:0]  mem_ts [DEPTH];
`endif

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign rd_valid = !empty;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign rd_data  = empty ? '0 : mem_data[head_q];
`ifdef PATTERN_CAPTURE_TIMESTAMP_EN
  assign rd_ts    = empty ? '0 : mem_ts[head_q];
`endif

  // A full buffer still accepts a capture when the head is popped on the same edge.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    last_d     = last_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    capture    = cap_en && (inputs != last_q);
    pop        = !empty && rd_ready;
    push       = capture && (!full || pop);

    if (cap_en)            last_d     = inputs;
    if (capture && !push)  overflow_d = 1'b1;
    if (push)              tail_d     = tail_q + AW'(1);
    if (pop)               head_d     = head_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      last_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      last_q     <= last_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: storage is not reset; empty masks stale contents on the read ports.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_data[tail_q] <= inputs;
`ifdef PATTERN_CAPTURE_TIMESTAMP_EN
      mem_ts[tail_q]   <= ts_cnt_q;
`endif
    end
  end

`ifdef PATTERN_CAPTURE_TIMESTAMP_EN
  always_ff @(posedge clk) begin
    if (rst) ts_cnt_q <= '0;
    else     ts_cnt_q <= ts_cnt_q + TS_W'(1);
  end
`endif

endmodule

// File: tb/tb_pattern_capture.sv
// Self-checking bench for pattern_capture: directed scenarios plus randomized traffic,
// compared against a queue-based reference model.
module tb_pattern_capture;
  localparam int WIDTH = 6;
  localparam int DEPTH = 16;
  localparam int TS_W  = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst, cap_en, rd_ready, rd_valid, full, empty, overflow;
  logic [WIDTH-1:0] inputs, rd_data;
  logic [CW-1:0]    count;
`ifdef PATTERN_CAPTURE_TIMESTAMP_EN
  logic [TS_W-1:0]  rd_ts;
`endif

  pattern_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .cap_en   (cap_en),
    .inputs   (inputs),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
`ifdef PATTERN_CAPTURE_TIMESTAMP_EN
    .rd_ts    (rd_ts),
`endif
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] pat;
    logic [TS_W-1:0]  ts;
  } entry_t;

  entry_t           mq[$];
  logic [WIDTH-1:0] m_last;
  logic [TS_W-1:0]  m_ts;
  bit               m_ovf;
  int               n_checks = 0;
  int               n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic compare_outputs(input string tag);
    int n;
    n = mq.size();
    check({tag, "_count"}, 32'(count), 32'(n));
    check({tag, "_empty"}, 32'(empty), 32'(n == 0));
    check({tag, "_full"}, 32'(full), 32'(n == DEPTH));
    check({tag, "_valid"}, 32'(rd_valid), 32'(n != 0));
    check({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    check({tag, "_data"}, 32'(rd_data), (n != 0) ? 32'(mq[0].pat) : 32'd0);
`ifdef PATTERN_CAPTURE_TIMESTAMP_EN
    check({tag, "_ts"}, 32'(rd_ts), (n != 0) ? 32'(mq[0].ts) : 32'd0);
`endif
  endtask

  // Drive one cycle, advance the reference model by the same edge, then compare.
  task automatic step(input logic en, input logic [WIDTH-1:0] pat, input logic rdy,
                      input logic rs, input string tag);
    bit     do_pop, do_cap;
    entry_t e;
    cap_en   = en;
    inputs   = pat;
    rd_ready = rdy;
    rst      = rs;
    @(posedge clk);
    if (rs) begin
      mq.delete();
      m_last = '0;
      m_ts   = '0;
      m_ovf  = 1'b0;
    end else begin
      do_pop = (mq.size() != 0) && rdy;
      do_cap = en && (pat != m_last);
      if (do_pop) void'(mq.pop_front());
      if (do_cap) begin
        if (mq.size() < DEPTH) begin
          e.pat = pat;
          e.ts  = m_ts;
          mq.push_back(e);
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (en) m_last = pat;
      m_ts = m_ts + TS_W'(1);
    end
    #1;
    compare_outputs(tag);
  endtask

  task automatic drain(input string tag);
    while (mq.size() != 0) step(1'b0, inputs, 1'b1, 1'b0, tag);
  endtask

  logic [WIDTH-1:0] exp_pat [4];
  logic [TS_W-1:0]  exp_ts  [4];
  logic [WIDTH-1:0] p, prev;
  logic [TS_W-1:0]  saved_ts;

  initial begin
    exp_pat = '{6'b011001, 6'b011011, 6'b011000, 6'b001000};
    exp_ts  = '{8'd10, 8'd20, 8'd30, 8'd40};
    m_last = '0; m_ts = '0; m_ovf = 1'b0;
    cap_en = 1'b0; inputs = '0; rd_ready = 1'b0; rst = 1'b1;

    step(1'b0, '0, 1'b0, 1'b1, "reset");
    step(1'b1, '0, 1'b1, 1'b1, "reset");

    // Four captures at cycles 10/20/30/40, nothing consumed.
    for (int c = 0; c < 45; c++) begin
      p = (c < 10) ? 6'b000000 : (c < 20) ? 6'b011001 : (c < 30) ? 6'b011011 :
          (c < 40) ? 6'b011000 : 6'b001000;
      step(1'b1, p, 1'b0, 1'b0, "seq4");
    end
    check("seq4_count_const", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("seq4_order_data", 32'(rd_data), 32'(exp_pat[i]));
`ifdef PATTERN_CAPTURE_TIMESTAMP_EN
      check("seq4_order_ts", 32'(rd_ts), 32'(exp_ts[i]));
`endif
      step(1'b1, 6'b001000, 1'b1, 1'b0, "seq4_pop");
    end

    // Constant input produces exactly one entry.
    for (int c = 0; c < 51; c++) step(1'b1, 6'b011001, 1'b0, 1'b0, "hold");
    check("hold_count_const", 32'(count), 32'd1);
    drain("hold_drain");

    // Changing every cycle overflows; first DEPTH patterns kept.
    prev = 6'b011001;
    for (int c = 0; c < 20; c++) begin
      do p = WIDTH'($urandom_range(0, 63)); while (p == prev);
      prev = p;
      step(1'b1, p, 1'b0, 1'b0, "toggle");
    end
    check("toggle_full_const", 32'(full), 32'd1);
    check("toggle_ovf_const", 32'(overflow), 32'd1);
    drain("toggle_drain");

    // Full buffer with simultaneous push and pop.
    step(1'b0, '0, 1'b0, 1'b1, "rst2");
    for (int i = 1; i <= DEPTH; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0, "fill");
    step(1'b1, 6'd40, 1'b1, 1'b0, "pushpop");
    check("pushpop_count_const", 32'(count), 32'd16);
    check("pushpop_ovf_const", 32'(overflow), 32'd0);
    drain("pushpop_drain");

    // Reset with five entries, then first capture gets timestamp 0.
    for (int i = 1; i <= 5; i++) step(1'b1, WIDTH'(i + 20), 1'b0, 1'b0, "five");
    check("five_count_const", 32'(count), 32'd5);
    step(1'b1, 6'd33, 1'b1, 1'b1, "rst_mid");
    check("rst_mid_empty_const", 32'(empty), 32'd1);
    check("rst_mid_valid_const", 32'(rd_valid), 32'd0);
    step(1'b1, 6'd9, 1'b0, 1'b0, "post_rst");
`ifdef PATTERN_CAPTURE_TIMESTAMP_EN
    check("post_rst_ts0", 32'(rd_ts), 32'd0);
`endif
    drain("post_rst_drain");

    // Disabled capture while input changes, then enable.
    step(1'b1, 6'b000000, 1'b1, 1'b0, "en_prep");
    drain("en_prep_drain");
    for (int c = 0; c < 3; c++) step(1'b0, 6'b011001, 1'b0, 1'b0, "en_off");
    check("en_off_count_const", 32'(count), 32'd0);
    saved_ts = m_ts;
    step(1'b1, 6'b011001, 1'b0, 1'b0, "en_on");
    check("en_on_data_const", 32'(rd_data), 32'(6'b011001));
`ifdef PATTERN_CAPTURE_TIMESTAMP_EN
    check("en_on_ts", 32'(rd_ts), 32'(saved_ts));
`endif
    drain("en_on_drain");

    // Randomized traffic: slow consumer first, then fast consumer.
    for (int c = 0; c < 300; c++)
      step(($urandom_range(0, 3) != 0), WIDTH'($urandom_range(0, 7)),
           (c < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 199) == 0), "rand");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
